// File: rtl/deparser_pkg.sv
// Shared bus widths, header sentinel and FSM encoding for the deparser write-back stage.
package deparser_pkg;

    localparam int unsigned WORD_WIDTH  = 32;
    localparam int unsigned NUM_HEADERS = 2;
    localparam int unsigned ADDR_BUS    = 32;
    localparam int unsigned DATA_BUS    = 32;
    localparam int unsigned IDX_W       = 8;

    localparam logic [WORD_WIDTH-1:0] NO_HEADER = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        StFree    = 2'd0,
        StWriting = 2'd1,
        StDone    = 2'd2
    } dp_state_e;

    function automatic logic [3:0] word_width(input logic [IDX_W-1:0] remaining);
        return (remaining >= 8'd4) ? 4'd4 : remaining[3:0];
    endfunction

endpackage

// File: rtl/hdr_word_slicer.sv
// Picks up to four bytes of the current header and left-aligns them into one write word.
module hdr_word_slicer
    import deparser_pkg::*;
#(
    parameter int unsigned HDR0_LEN  = 14,
    parameter int unsigned HDR1_LEN  = 20,
    parameter int unsigned HDR_BYTES = HDR0_LEN + HDR1_LEN
) (
    input  logic [8*HDR_BYTES-1:0] hdr_data,
    input  logic                   hdr_id,
    input  logic [IDX_W-1:0]       byte_idx,
    output logic [DATA_BUS-1:0]    word,
    output logic [3:0]             width,
    output logic                   last
);

    localparam logic [IDX_W-1:0] LEN0 = IDX_W'(HDR0_LEN);
    localparam logic [IDX_W-1:0] LEN1 = IDX_W'(HDR1_LEN);

    logic [IDX_W-1:0] base;
    logic [IDX_W-1:0] len;
    logic [IDX_W-1:0] remaining;
    int unsigned      pos;

    always_comb begin
        base      = hdr_id ? LEN0 : '0;
        len       = hdr_id ? LEN1 : LEN0;
        remaining = len - byte_idx;
        width     = word_width(remaining);
        last      = (remaining <= 8'd4);
        word      = '0;
        pos       = 0;
        for (int b = 0; b < 4; b++) begin
            pos = 32'(base) + 32'(byte_idx) + 32'(b);
            // Byte 0 of the flattened vector sits in the MSB byte.
            if ((4'(b) < width) && (pos < HDR_BYTES)) begin
                word[DATA_BUS-1-8*b -: 8] = hdr_data[8*(HDR_BYTES-1-pos) +: 8];
            end
        end
    end

endmodule

// File: rtl/deparser.sv
// Writes latched header bytes back to packet memory at the parser's offsets, one word per cycle.
module deparser
    import deparser_pkg::*;
#(
    parameter int unsigned HDR0_LEN  = 14,
    parameter int unsigned HDR1_LEN  = 20,
    parameter int unsigned HDR_BYTES = HDR0_LEN + HDR1_LEN
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start_i,
    input  logic [WORD_WIDTH*NUM_HEADERS-1:0] parsed_hdrs_i,
    input  logic [8*HDR_BYTES-1:0]            hdr_data_i,
    output logic                              mem_ce_o,
    output logic                              mem_we_o,
    output logic [ADDR_BUS-1:0]               mem_addr_o,
    output logic [3:0]                        mem_width_o,
    output logic [DATA_BUS-1:0]               mem_data_o,
    input  logic [DATA_BUS-1:0]               mem_data_i,
    output logic                              deparse_done_o
);

    dp_state_e                         state_q, state_d;
    logic                              hdr_id_q, hdr_id_d;
    logic [IDX_W-1:0]                  byte_idx_q, byte_idx_d;
    logic [WORD_WIDTH*NUM_HEADERS-1:0] offs_q, offs_d;
    logic [8*HDR_BYTES-1:0]            data_q, data_d;
    logic                              done_q, done_d;

    logic [DATA_BUS-1:0] slice_word;
    logic [3:0]          slice_width;
    logic                slice_last;
    logic [ADDR_BUS-1:0] cur_off;
    logic                in_present0, in_present1, present1;
    logic                unused_mem_data;

    assign unused_mem_data = ^mem_data_i;

    assign in_present0 = parsed_hdrs_i[2*WORD_WIDTH-1:WORD_WIDTH] != NO_HEADER;
    assign in_present1 = parsed_hdrs_i[WORD_WIDTH-1:0] != NO_HEADER;
    assign present1    = offs_q[WORD_WIDTH-1:0] != NO_HEADER;
    assign cur_off     = hdr_id_q ? offs_q[WORD_WIDTH-1:0] : offs_q[2*WORD_WIDTH-1:WORD_WIDTH];

    hdr_word_slicer #(
        .HDR0_LEN (HDR0_LEN),
        .HDR1_LEN (HDR1_LEN),
        .HDR_BYTES(HDR_BYTES)
    ) u_slicer (
        .hdr_data(data_q),
        .hdr_id  (hdr_id_q),
        .byte_idx(byte_idx_q),
        .word    (slice_word),
        .width   (slice_width),
        .last    (slice_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StFree;
            hdr_id_q   <= 1'b0;
            byte_idx_q <= '0;
            offs_q     <= {NUM_HEADERS{NO_HEADER}};
            data_q     <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hdr_id_q   <= hdr_id_d;
            byte_idx_q <= byte_idx_d;
            offs_q     <= offs_d;
            data_q     <= data_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        hdr_id_d       = hdr_id_q;
        byte_idx_d     = byte_idx_q;
        offs_d         = offs_q;
        data_d         = data_q;
        done_d         = done_q;
        mem_ce_o       = 1'b0;
        mem_we_o       = 1'b0;
        mem_addr_o     = '0;
        mem_width_o    = '0;
        mem_data_o     = '0;
        deparse_done_o = done_q;

        case (state_q)
            StFree: begin
                if (start_i) begin
                    offs_d     = parsed_hdrs_i;
                    data_d     = hdr_data_i;
                    done_d     = 1'b0;
                    byte_idx_d = '0;
                    // Header selection uses the live inputs; the latched copy lands this edge.
                    if (in_present0) begin
                        hdr_id_d = 1'b0;
                        state_d  = StWriting;
                    end else if (in_present1) begin
                        hdr_id_d = 1'b1;
                        state_d  = StWriting;
                    end else begin
                        done_d  = 1'b1;
                        state_d = StDone;
                    end
                end
            end
            StWriting: begin
                mem_ce_o    = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = cur_off + ADDR_BUS'(byte_idx_q);
                mem_width_o = slice_width;
                mem_data_o  = slice_word;
                if (slice_last) begin
                    if (!hdr_id_q && present1) begin
                        hdr_id_d   = 1'b1;
                        byte_idx_d = '0;
                    end else begin
                        done_d  = 1'b1;
                        state_d = StDone;
                    end
                end else begin
                    byte_idx_d = byte_idx_q + IDX_W'(4);
                end
            end
            StDone: begin
                if (!start_i) begin
                    state_d = StFree;
                end
            end
            default: state_d = StFree;
        endcase
    end

endmodule

// File: tb/tb_deparser.sv
// Self-checking bench: table-driven deparse runs plus latch, reset and start-hold sequences.
module tb_deparser;
    import deparser_pkg::*;

    localparam int unsigned HDR0_LEN  = 14;
    localparam int unsigned HDR1_LEN  = 20;
    localparam int unsigned HDR_BYTES = HDR0_LEN + HDR1_LEN;

    logic                              clk = 1'b0;
    logic                              rst;
    logic                              start_i;
    logic [WORD_WIDTH*NUM_HEADERS-1:0] parsed_hdrs_i;
    logic [8*HDR_BYTES-1:0]            hdr_data_i;
    logic                              mem_ce_o, mem_we_o;
    logic [ADDR_BUS-1:0]               mem_addr_o;
    logic [3:0]                        mem_width_o;
    logic [DATA_BUS-1:0]               mem_data_o;
    logic [DATA_BUS-1:0]               mem_data_i;
    logic                              deparse_done_o;

    deparser #(
        .HDR0_LEN (HDR0_LEN),
        .HDR1_LEN (HDR1_LEN),
        .HDR_BYTES(HDR_BYTES)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_i),
        .parsed_hdrs_i (parsed_hdrs_i),
        .hdr_data_i    (hdr_data_i),
        .mem_ce_o      (mem_ce_o),
        .mem_we_o      (mem_we_o),
        .mem_addr_o    (mem_addr_o),
        .mem_width_o   (mem_width_o),
        .mem_data_o    (mem_data_o),
        .mem_data_i    (mem_data_i),
        .deparse_done_o(deparse_done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  width;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [31:0] off0;
        logic [31:0] off1;
        logic [7:0]  seed;
        int          nwr;
        int          lat;
    } vec_t;

    wr_t        exp_q[$];
    vec_t       vecs[5];
    logic [7:0] bytes_m[HDR_BYTES];
    int         checks = 0;
    int         passes = 0;
    int         writes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic check_idle(input string name);
        check({name, "_ce"}, 32'(mem_ce_o), 32'd0);
        check({name, "_we"}, 32'(mem_we_o), 32'd0);
        check({name, "_addr"}, mem_addr_o, 32'd0);
        check({name, "_width"}, 32'(mem_width_o), 32'd0);
        check({name, "_data"}, mem_data_o, 32'd0);
        check({name, "_done"}, 32'(deparse_done_o), 32'd0);
    endtask

    // Drive the inputs and push the writes a correct deparser must produce.
    task automatic load(input logic [31:0] o0, input logic [31:0] o1, input logic [7:0] seed);
        int          len[2];
        int          base[2];
        logic [31:0] offs[2];
        int          w;
        logic [31:0] d;
        len  = '{HDR0_LEN, HDR1_LEN};
        base = '{0, HDR0_LEN};
        offs = '{o0, o1};
        for (int j = 0; j < HDR_BYTES; j++) begin
            bytes_m[j] = 8'(j) ^ seed;
            hdr_data_i[8*(HDR_BYTES-1-j) +: 8] = bytes_m[j];
        end
        parsed_hdrs_i = {o0, o1};
        for (int h = 0; h < 2; h++) begin
            if (offs[h] != 32'hFFFF_FFFF) begin
                for (int bi = 0; bi < len[h]; bi += 4) begin
                    w = (len[h] - bi < 4) ? len[h] - bi : 4;
                    d = '0;
                    for (int b = 0; b < w; b++) d[31-8*b -: 8] = bytes_m[base[h]+bi+b];
                    exp_q.push_back('{offs[h] + 32'(bi), 4'(w), d});
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst && mem_ce_o) begin
            writes++;
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_write: got addr 0x%08h, expected no write", mem_addr_o);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", mem_addr_o, e.addr);
                check("wr_width", 32'(mem_width_o), 32'(e.width));
                check("wr_data", mem_data_o, e.data);
                check("wr_we", 32'(mem_we_o), 32'd1);
            end
        end
    end

    task automatic wait_done(input string name, input vec_t v);
        int n;
        n = 0;
        while (!deparse_done_o && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, "_done_latency"}, 32'(n), 32'(v.lat));
        check({name, "_writes"}, 32'(writes), 32'(v.nwr));
        check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
        check({name, "_ce_in_done"}, 32'(mem_ce_o), 32'd0);
    endtask

    task automatic run(input vec_t v, input bit perturb, input string name);
        @(posedge clk);
        #1;
        load(v.off0, v.off1, v.seed);
        writes  = 0;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        check({name, "_done_after_start"}, 32'(deparse_done_o), 32'(v.lat == 0));
        if (perturb) begin
            for (int j = 0; j < HDR_BYTES; j++) hdr_data_i[8*j +: 8] = 8'($urandom);
            parsed_hdrs_i = {32'd200, 32'd300};
        end
        wait_done(name, v);
    endtask

    initial begin
        vecs[0] = '{32'h0000_0000, 32'd14, 8'h00, 9, 9};
        vecs[1] = '{32'd64, 32'hFFFF_FFFF, 8'h11, 4, 4};
        vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'h22, 0, 0};
        vecs[3] = '{32'hFFFF_FFFF, 32'd100, 8'h33, 5, 5};
        vecs[4] = '{32'hFFFF_FFFE, 32'd16, 8'h44, 9, 9};

        rst           = 1'b1;
        start_i       = 1'b0;
        parsed_hdrs_i = '0;
        hdr_data_i    = '0;
        mem_data_i    = '0;
        #1;
        check_idle("in_reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_idle("after_reset");

        for (int i = 0; i < 5; i++) run(vecs[i], 1'b0, $sformatf("vec%0d", i));

        // Inputs change right after start; writes must follow the latched copy.
        run('{32'd0, 32'd14, 8'h77, 9, 9}, 1'b1, "latch");

        // Reset lands during the third write word.
        @(posedge clk);
        #1;
        load(32'd0, 32'd14, 8'h66);
        writes  = 0;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_idle("rst_mid_write");
        check("rst_mid_write_count", 32'(writes), 32'd3);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        run(vecs[0], 1'b0, "after_rst");

        // Start held high through DONE must not retrigger.
        @(posedge clk);
        #1;
        load(32'd0, 32'd14, 8'h5A);
        writes  = 0;
        start_i = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("hold_writes", 32'(writes), 32'd9);
        check("hold_done", 32'(deparse_done_o), 32'd1);
        check("hold_pending", 32'(exp_q.size()), 32'd0);
        start_i = 1'b0;
        run('{32'd0, 32'd14, 8'hA5, 9, 9}, 1'b0, "restart");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
